s_axi4l_interface: RTL and testbench



---
 rtl/s_axi4l_interface.sv | 124 ++++++++++++
 tb/tb_s_axi4l_interface.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/s_axi4l_interface.sv
// AXI4-Lite slave bridging the host CPU to the SNN core: pixel uploads,
// a NEW_IMAGE control level, and read-back of the inferred digit.
module s_axi4l_interface #(
    parameter int N               = 256,
    parameter int M               = 8,
    parameter int AXI_DATA_WIDTH  = 32,
    parameter int AXI_ADDR_WIDTH  = 32,
    parameter int IMAGE_SIZE      = 256,
    parameter int IMAGE_SIZE_BITS = 8,
    parameter int PIXEL_MAX_VALUE = 255,
    parameter int PIXEL_BITS      = 8
) (
    input  logic                                  ACLK,
    input  logic                                  ARESETN,
    input  logic [AXI_ADDR_WIDTH-1:0]             AWADDR,
    input  logic [2:0]                            AWPROT,
    input  logic                                  AWVALID,
    output logic                                  AWREADY,
    input  logic [AXI_DATA_WIDTH-1:0]             WDATA,
    input  logic [AXI_DATA_WIDTH/8-1:0]           WSTRB,
    input  logic                                  WVALID,
    output logic                                  WREADY,
    output logic [1:0]                            BRESP,
    output logic                                  BVALID,
    input  logic                                  BREADY,
    input  logic [AXI_ADDR_WIDTH-1:0]             ARADDR,
    input  logic [2:0]                            ARPROT,
    input  logic                                  ARVALID,
    output logic                                  ARREADY,
    output logic [AXI_DATA_WIDTH-1:0]             RDATA,
    output logic [1:0]                            RRESP,
    output logic                                  RVALID,
    input  logic                                  RREADY,
    input  logic [M-1:0]                          INFERED_DIGIT,
    output logic [0:IMAGE_SIZE-1][PIXEL_BITS-1:0] IMAGE,
    output logic                                  NEW_IMAGE
);

    localparam logic [AXI_ADDR_WIDTH-1:0] CTRL_ADDR = AXI_ADDR_WIDTH'(IMAGE_SIZE);

    logic [PIXEL_BITS-1:0]     image_data [0:IMAGE_SIZE-1];
    logic [AXI_ADDR_WIDTH-1:0] ar_addr;
    logic [AXI_DATA_WIDTH-1:0] rd_word;
    logic                      wr_go;
    logic                      rd_go;
    logic                      wr_pixel;
    logic                      wr_ctrl;

    assign BRESP = 2'b00;
    assign RRESP = 2'b00;

    // Both address and data must be present; no partial acceptance.
    assign wr_go    = AWVALID && WVALID && !BVALID && !AWREADY && !WREADY;
    assign rd_go    = ARVALID && !RVALID && !ARREADY;
    assign wr_pixel = (AWADDR < CTRL_ADDR);
    assign wr_ctrl  = (AWADDR == CTRL_ADDR);

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            AWREADY   <= 1'b0;
            WREADY    <= 1'b0;
            BVALID    <= 1'b0;
            NEW_IMAGE <= 1'b0;
            for (int i = 0; i < IMAGE_SIZE; i++) begin
                image_data[i] <= '0;
            end
        end else begin
            AWREADY <= wr_go;
            WREADY  <= wr_go;
            if (BVALID && BREADY) begin
                BVALID <= 1'b0;
            end else if (AWREADY && WREADY) begin
                BVALID <= 1'b1;
            end
            if (wr_go && WSTRB[0]) begin
                if (wr_pixel) begin
                    image_data[AWADDR[IMAGE_SIZE_BITS-1:0]] <= WDATA[PIXEL_BITS-1:0];
                end else if (wr_ctrl) begin
                    NEW_IMAGE <= WDATA[0];
                end
            end
        end
    end

    always_comb begin
        rd_word = '0;
        if (ar_addr == '0) begin
            rd_word[M-1:0] = INFERED_DIGIT;
        end else if (ar_addr == CTRL_ADDR) begin
            rd_word[0] = NEW_IMAGE;
        end
    end

    // RDATA is captured once per read so it stays stable while RVALID waits.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            ARREADY <= 1'b0;
            RVALID  <= 1'b0;
            RDATA   <= '0;
            ar_addr <= '0;
        end else begin
            ARREADY <= rd_go;
            if (rd_go) begin
                ar_addr <= ARADDR;
            end
            if (ARREADY) begin
                RVALID <= 1'b1;
                RDATA  <= rd_word;
            end else if (RVALID && RREADY) begin
                RVALID <= 1'b0;
            end
        end
    end

    for (genvar g = 0; g < IMAGE_SIZE; g++) begin : g_image
        assign IMAGE[g] = image_data[g];
    end

    logic unused_inputs;
    assign unused_inputs = ^{AWPROT, ARPROT, WSTRB[AXI_DATA_WIDTH/8-1:1],
                             WDATA[AXI_DATA_WIDTH-1:PIXEL_BITS]}
                           ^ (N == 0) ^ (PIXEL_MAX_VALUE == 0);

endmodule

// File: tb/tb_s_axi4l_interface.sv
// Scoreboard bench for s_axi4l_interface: directed AXI-Lite transactions,
// expected B/R responses queued at issue and checked by a separate monitor.
module tb_s_axi4l_interface;

    localparam int IMG = 256;

    logic                   ACLK = 1'b0;
    logic                   ARESETN = 1'b0;
    logic [31:0]            AWADDR, WDATA, ARADDR, RDATA;
    logic [2:0]             AWPROT, ARPROT;
    logic [3:0]             WSTRB;
    logic                   AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic                   ARVALID, ARREADY, RVALID, RREADY, NEW_IMAGE;
    logic [1:0]             BRESP, RRESP;
    logic [7:0]             INFERED_DIGIT;
    logic [0:IMG-1][7:0]    IMAGE;

    int errors = 0;
    int checks = 0;
    logic [1:0]  bq[$];
    logic [31:0] rq[$];

    s_axi4l_interface dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .INFERED_DIGIT(INFERED_DIGIT), .IMAGE(IMAGE), .NEW_IMAGE(NEW_IMAGE)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] pix(input int i);
        case (i)
            56:      return 8'd3;
            57:      return 8'd32;
            76:      return 8'd244;
            default: return 8'((i * 37 + 11) % 256);
        endcase
    endfunction

    // Monitor: pops an expectation whenever a response handshake is presented.
    always @(negedge ACLK) begin
        if (ARESETN) begin
            if (BVALID && BREADY) begin
                if (bq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL b_unexpected: got BVALID=1 expected no response");
                end else begin
                    chk("bresp", 32'(BRESP), 32'(bq.pop_front()));
                end
            end
            if (RVALID && RREADY) begin
                if (rq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL r_unexpected: got RVALID=1 expected no response");
                end else begin
                    chk("rdata", RDATA, rq.pop_front());
                    chk("rresp", 32'(RRESP), 32'd0);
                end
            end
        end
    end

    task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input int wdly);
        int n;
        bq.push_back(2'b00);
        AWADDR = a; WDATA = d; WSTRB = s;
        AWVALID = 1'b1; WVALID = (wdly == 0);
        for (int k = 0; k < wdly; k++) begin
            @(posedge ACLK); #1;
            chk("aw_waits_for_w", 32'(AWREADY), 32'd0);
        end
        WVALID = 1'b1;
        n = 0;
        while (!AWREADY && n < 20) begin
            @(posedge ACLK); #1;
            n++;
        end
        if (!AWREADY) begin
            checks++; errors++;
            $display("FAIL aw_timeout: got AWREADY=0 expected 1 within 20 cycles");
            void'(bq.pop_back());
        end else begin
            chk("wready_with_awready", 32'(WREADY), 32'd1);
        end
        @(posedge ACLK); #1;
        AWVALID = 1'b0; WVALID = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] exp);
        int n;
        rq.push_back(exp);
        ARADDR = a; ARVALID = 1'b1;
        n = 0;
        while (!ARREADY && n < 20) begin
            @(posedge ACLK); #1;
            n++;
        end
        if (!ARREADY) begin
            checks++; errors++;
            $display("FAIL ar_timeout: got ARREADY=0 expected 1 within 20 cycles");
            void'(rq.pop_back());
        end
        @(posedge ACLK); #1;
        ARVALID = 1'b0;
    endtask

    task automatic wait_b();
        int n;
        n = 0;
        while (bq.size() != 0 && n < 30) begin
            @(posedge ACLK); n++;
        end
        #1;
        if (bq.size() != 0) begin
            checks++; errors++;
            $display("FAIL b_timeout: got %0d pending expected 0", bq.size());
            bq.delete();
        end
    endtask

    task automatic wait_r();
        int n;
        n = 0;
        while (rq.size() != 0 && n < 30) begin
            @(posedge ACLK); n++;
        end
        #1;
        if (rq.size() != 0) begin
            checks++; errors++;
            $display("FAIL r_timeout: got %0d pending expected 0", rq.size());
            rq.delete();
        end
    endtask

    task automatic check_image(input string name, input logic zero);
        int bad_store, bad_port;
        bad_store = 0; bad_port = 0;
        for (int i = 0; i < IMG; i++) begin
            if (dut.image_data[i] !== (zero ? 8'd0 : pix(i))) bad_store++;
            if (IMAGE[i] !== (zero ? 8'd0 : pix(i))) bad_port++;
        end
        chk({name, "_store"}, 32'(bad_store), 32'd0);
        chk({name, "_port"}, 32'(bad_port), 32'd0);
    endtask

    initial begin
        AWADDR = '0; WDATA = '0; ARADDR = '0; AWPROT = '0; ARPROT = '0; WSTRB = '0;
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
        BREADY = 1'b1; RREADY = 1'b1; INFERED_DIGIT = '0;

        // Reset state
        repeat (3) @(posedge ACLK);
        #1;
        chk("rst_awready", 32'(AWREADY), 32'd0);
        chk("rst_wready", 32'(WREADY), 32'd0);
        chk("rst_bvalid", 32'(BVALID), 32'd0);
        chk("rst_arready", 32'(ARREADY), 32'd0);
        chk("rst_rvalid", 32'(RVALID), 32'd0);
        chk("rst_rdata", RDATA, 32'd0);
        chk("rst_new_image", 32'(NEW_IMAGE), 32'd0);
        chk("rst_resp", 32'({BRESP, RRESP}), 32'd0);
        check_image("rst_image", 1'b1);
        @(negedge ACLK);
        ARESETN = 1'b1;
        @(posedge ACLK); #1;

        // Full image upload; upper data bits must be dropped
        for (int i = 0; i < IMG; i++) begin
            do_write(32'(i), {24'h5A5A5A, pix(i)}, 4'h1, (i == 3) ? 2 : 0);
            wait_b();
        end
        check_image("pixels", 1'b0);
        chk("pix56", 32'(dut.image_data[56]), 32'd3);
        chk("pix57", 32'(dut.image_data[57]), 32'd32);
        chk("pix76", 32'(IMAGE[76]), 32'd244);

        // Control register
        do_write(32'd256, 32'd1, 4'h1, 0); wait_b();
        chk("new_image_set", 32'(NEW_IMAGE), 32'd1);
        do_read(32'd256, 32'd1); wait_r();
        do_write(32'd256, 32'd0, 4'h1, 0); wait_b();
        chk("new_image_clr", 32'(NEW_IMAGE), 32'd0);
        do_read(32'd256, 32'd0); wait_r();
        check_image("pixels_after_ctrl", 1'b0);

        // Digit read-back and unmapped reads
        INFERED_DIGIT = 8'd5;
        do_read(32'd0, 32'd5); wait_r();
        do_read(32'd5, 32'd0); wait_r();
        do_read(32'd257, 32'd0); wait_r();

        // Writes with no effect
        do_write(32'd300, 32'd7, 4'h1, 0); wait_b();
        do_write(32'd10, 32'hAB, 4'h0, 0); wait_b();
        do_write(32'd256, 32'd1, 4'h0, 0); wait_b();
        chk("noeffect_new_image", 32'(NEW_IMAGE), 32'd0);
        chk("noeffect_pix10", 32'(dut.image_data[10]), 32'(pix(10)));
        check_image("pixels_after_noeffect", 1'b0);

        // Simultaneous read and write
        bq.push_back(2'b00); rq.push_back(32'd5);
        AWADDR = 32'd100; WDATA = 32'h77; WSTRB = 4'h1; ARADDR = 32'd0;
        AWVALID = 1'b1; WVALID = 1'b1; ARVALID = 1'b1;
        @(posedge ACLK); #1;
        chk("simul_awready", 32'(AWREADY), 32'd1);
        chk("simul_arready", 32'(ARREADY), 32'd1);
        @(posedge ACLK); #1;
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
        wait_b(); wait_r();
        chk("simul_pix100", 32'(dut.image_data[100]), 32'h77);

        // BREADY held low: response held, next write blocked
        BREADY = 1'b0;
        do_write(32'd6, 32'h44, 4'h1, 0);
        AWADDR = 32'd7; WDATA = 32'h99; WSTRB = 4'h1; AWVALID = 1'b1; WVALID = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge ACLK); #1;
            chk("bvalid_hold", 32'(BVALID), 32'd1);
            chk("aw_blocked", 32'(AWREADY), 32'd0);
        end
        chk("blocked_pix7", 32'(dut.image_data[7]), 32'(pix(7)));
        chk("held_pix6", 32'(dut.image_data[6]), 32'h44);
        AWVALID = 1'b0; WVALID = 1'b0; BREADY = 1'b1;
        wait_b();

        // RREADY held low: data stable, next read blocked
        RREADY = 1'b0;
        do_read(32'd0, 32'd5);
        ARADDR = 32'd256; ARVALID = 1'b1; INFERED_DIGIT = 8'd9;
        for (int k = 0; k < 5; k++) begin
            @(posedge ACLK); #1;
            chk("rvalid_hold", 32'(RVALID), 32'd1);
            chk("rdata_hold", RDATA, 32'd5);
            chk("ar_blocked", 32'(ARREADY), 32'd0);
        end
        ARVALID = 1'b0; RREADY = 1'b1;
        wait_r();
        do_read(32'd0, 32'd9); wait_r();

        // Reset in the middle of a pending write response
        do_write(32'd256, 32'd1, 4'h1, 0); wait_b();
        chk("new_image_before_rst", 32'(NEW_IMAGE), 32'd1);
        BREADY = 1'b0;
        do_write(32'd20, 32'h55, 4'h1, 0);
        chk("bvalid_before_rst", 32'(BVALID), 32'd1);
        #2;
        ARESETN = 1'b0;
        #1;
        bq.delete(); rq.delete();
        chk("midrst_bvalid", 32'(BVALID), 32'd0);
        chk("midrst_new_image", 32'(NEW_IMAGE), 32'd0);
        chk("midrst_rdata", RDATA, 32'd0);
        check_image("midrst_image", 1'b1);
        @(negedge ACLK);
        ARESETN = 1'b1;
        BREADY = 1'b1;
        repeat (2) @(posedge ACLK);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
